// File: rtl/ex_stage_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_pipe_if
// Purpose  : Decode-side and writeback-side handshake bundle for ex_stage_pipe.
// Revision : 1.0  initial release
// ============================================================================
interface ex_stage_pipe_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        first_ld;
    logic              special_enc;
    logic [2:0]        alu_oc;
    logic [3:0]        b_cond;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   offset;
    logic [PC_W-1:0]   pc;
    logic [3:0]        flags_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic [3:0]        flags_out;
    logic              flags_we;
    logic              br_taken;
    logic [PC_W-1:0]   br_target;

    modport master (
        output in_valid, first_ld, special_enc, alu_oc, b_cond,
               op1, op2, imm, offset, pc, flags_in, out_ready,
        input  in_ready, out_valid, result, flags_out, flags_we,
               br_taken, br_target
    );

    modport slave (
        input  in_valid, first_ld, special_enc, alu_oc, b_cond,
               op1, op2, imm, offset, pc, flags_in, out_ready,
        output in_ready, out_valid, result, flags_out, flags_we,
               br_taken, br_target
    );
endinterface
`default_nettype wire

// File: rtl/ex_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_pipe
// Purpose  : Handshaked execute stage: ALU, move/shift and branch resolution
//            with registered outputs. Define EX_BARREL_SHIFT_EN for 1-cycle
//            shifts; otherwise LSL/LSR iterate one bit per cycle.
// Revision : 1.0  initial release
// ============================================================================
module ex_stage_pipe #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16
) (
    input  logic           clk,
    input  logic           rst,
    ex_stage_pipe_if.slave bus
);
    localparam int SHAMT_W = $clog2(DATA_W);
    localparam logic [SHAMT_W:0]  c_amt_limit = (SHAMT_W+1)'(DATA_W);
    localparam logic [SHAMT_W:0]  c_cnt_one   = (SHAMT_W+1)'(1);
    localparam logic [DATA_W-1:0] c_bit_one   = DATA_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_result;
    logic [3:0]         r_flags;
    logic               r_flags_we;
    logic               r_br_taken;
    logic [PC_W-1:0]    r_br_target;
    logic [DATA_W-1:0]  r_shift_val;
    logic               r_shift_left;
    logic [SHAMT_W:0]   r_shift_cnt;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_start_shift;
    logic               w_shift_done;
    logic [DATA_W-1:0]  w_shift_step;
    logic [DATA_W-1:0]  w_b;
    logic [DATA_W:0]    w_sum;
    logic [DATA_W:0]    w_diff;
    logic [SHAMT_W:0]   w_amount;
    logic [DATA_W-1:0]  w_mask;
    logic [PC_W-1:0]    w_op1_pc;
    logic               w_cond;
    logic               w_c;
    logic               w_v;
    logic [DATA_W-1:0]  w_result;
    logic [3:0]         w_flags;
    logic               w_flags_we;
    logic               w_br_taken;
    logic [PC_W-1:0]    w_br_target;

    assign w_in_ready = (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    assign w_b      = bus.first_ld[0] ? bus.op2 : bus.imm;
    assign w_sum    = {1'b0, bus.op1} + {1'b0, w_b};
    assign w_diff   = {1'b0, bus.op1} - {1'b0, w_b};
    assign w_amount = bus.imm[SHAMT_W:0];
    assign w_mask   = c_bit_one << bus.imm[SHAMT_W-1:0];
    assign w_shift_step = r_shift_left ? (r_shift_val << 1) : (r_shift_val >> 1);

    generate
        if (PC_W > DATA_W) begin : g_op1_pc_zext
            assign w_op1_pc = {{(PC_W-DATA_W){1'b0}}, bus.op1};
        end else begin : g_op1_pc_trunc
            assign w_op1_pc = bus.op1[PC_W-1:0];
        end
    endgenerate

    // flags_in is {N,Z,C,V}
    always_comb begin
        w_cond = 1'b0;
        case (bus.b_cond)
            4'd0:    w_cond =  bus.flags_in[2];
            4'd1:    w_cond = !bus.flags_in[2];
            4'd2:    w_cond =  bus.flags_in[1];
            4'd3:    w_cond = !bus.flags_in[1];
            4'd4:    w_cond =  bus.flags_in[3];
            4'd5:    w_cond = !bus.flags_in[3];
            4'd6:    w_cond =  bus.flags_in[0];
            4'd7:    w_cond = !bus.flags_in[0];
            4'd8:    w_cond =  bus.flags_in[1] && !bus.flags_in[2];
            4'd9:    w_cond = !bus.flags_in[1] ||  bus.flags_in[2];
            4'd10:   w_cond = (bus.flags_in[3] == bus.flags_in[0]);
            4'd11:   w_cond = (bus.flags_in[3] != bus.flags_in[0]);
            4'd12:   w_cond = !bus.flags_in[2] && (bus.flags_in[3] == bus.flags_in[0]);
            4'd13:   w_cond =  bus.flags_in[2] || (bus.flags_in[3] != bus.flags_in[0]);
            4'd14:   w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_result      = '0;
        w_flags       = '0;
        w_flags_we    = 1'b0;
        w_br_taken    = 1'b0;
        w_br_target   = '0;
        w_start_shift = 1'b0;
        w_c           = bus.flags_in[1];
        w_v           = bus.flags_in[0];
        if (bus.special_enc) begin
            w_flags_we = 1'b1;
            case (bus.alu_oc)
                3'b001: begin
                    w_result = w_sum[DATA_W-1:0];
                    w_c      = w_sum[DATA_W];
                    w_v      = (bus.op1[DATA_W-1] == w_b[DATA_W-1]) &&
                               (w_sum[DATA_W-1] != bus.op1[DATA_W-1]);
                end
                3'b010: begin
                    w_result = w_diff[DATA_W-1:0];
                    w_c      = !w_diff[DATA_W];
                    w_v      = (bus.op1[DATA_W-1] != w_b[DATA_W-1]) &&
                               (w_diff[DATA_W-1] != bus.op1[DATA_W-1]);
                end
                3'b011:  w_result = bus.op1 & w_b;
                3'b100:  w_result = bus.op1 | w_b;
                3'b101:  w_result = bus.op1 ^ w_b;
                3'b110:  w_result = ~bus.op1;
                default: w_flags_we = 1'b0;
            endcase
            if (w_flags_we) begin
                w_flags = {w_result[DATA_W-1], (w_result == '0), w_c, w_v};
            end
        end else if (bus.first_ld == 2'b00) begin
            case (bus.alu_oc)
                3'b000: w_result = bus.imm;
                3'b001: w_result = {bus.imm[DATA_W/2-1:0], bus.op1[DATA_W/2-1:0]};
                3'b010: w_result = bus.op1 & ~w_mask;
                3'b011: w_result = bus.op1 | w_mask;
                3'b100, 3'b101: begin
`ifdef EX_BARREL_SHIFT_EN
                    if (w_amount >= c_amt_limit) begin
                        w_result = '0;
                    end else if (bus.alu_oc[0]) begin
                        w_result = bus.op1 >> w_amount;
                    end else begin
                        w_result = bus.op1 << w_amount;
                    end
`else
                    // Zero and out-of-range amounts finish at accept; the rest iterate.
                    if (w_amount >= c_amt_limit) begin
                        w_result = '0;
                    end else if (w_amount == '0) begin
                        w_result = bus.op1;
                    end else begin
                        w_start_shift = 1'b1;
                    end
`endif
                end
                default: w_result = '0;
            endcase
        end else begin
            case (bus.alu_oc)
                3'b000: begin
                    w_br_taken  = 1'b1;
                    w_br_target = bus.pc + bus.offset;
                end
                3'b001: begin
                    w_br_taken  = w_cond;
                    w_br_target = bus.pc + bus.offset;
                end
                3'b010: begin
                    w_br_taken  = 1'b1;
                    w_br_target = w_op1_pc;
                end
                default: w_br_taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shift_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_start_shift) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_shift_cnt == c_cnt_one) begin
                    w_shift_done = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift_val  <= '0;
            r_shift_left <= 1'b0;
            r_shift_cnt  <= '0;
        end else if (w_accept && w_start_shift) begin
            r_shift_val  <= bus.op1;
            r_shift_left <= !bus.alu_oc[0];
            r_shift_cnt  <= w_amount;
        end else if (r_state == ST_SHIFT) begin
            r_shift_val  <= w_shift_step;
            r_shift_cnt  <= r_shift_cnt - c_cnt_one;
        end
    end

    // Output registers only move on a new result; otherwise they hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_flags_we  <= 1'b0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
        end else if (w_accept && !w_start_shift) begin
            r_out_valid <= 1'b1;
            r_result    <= w_result;
            r_flags     <= w_flags;
            r_flags_we  <= w_flags_we;
            r_br_taken  <= w_br_taken;
            r_br_target <= w_br_target;
        end else if (w_shift_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_shift_step;
            r_flags     <= '0;
            r_flags_we  <= 1'b0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.flags_out = r_flags;
    assign bus.flags_we  = r_flags_we && r_out_valid;
    assign bus.br_taken  = r_br_taken && r_out_valid;
    assign bus.br_target = r_br_target;
endmodule
`default_nettype wire

// File: tb/tb_ex_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage_pipe
// Purpose  : Directed vector table plus backpressure/throughput/reset sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_stage_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    ex_stage_pipe_if #(.DATA_W(16), .PC_W(16)) bus ();

    ex_stage_pipe #(.DATA_W(16), .PC_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        spec;
        logic [1:0]  fl;
        logic [2:0]  oc;
        logic [3:0]  cond;
        logic [15:0] op1, op2, imm, pc, off;
        logic [3:0]  fin;
        logic [15:0] e_res;
        logic [3:0]  e_flags;
        logic        e_we;
        logic        e_tk;
        logic [15:0] e_tgt;
        logic        chk_tgt;
        int          lat;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(string name, logic spec, logic [1:0] fl, logic [2:0] oc,
                                logic [3:0] cond, logic [15:0] op1, logic [15:0] op2,
                                logic [15:0] imm, logic [15:0] pc, logic [15:0] off,
                                logic [3:0] fin, logic [15:0] e_res, logic [3:0] e_flags,
                                logic e_we, logic e_tk, logic [15:0] e_tgt, logic chk_tgt,
                                int lat);
        vec_t v;
        v.name = name; v.spec = spec; v.fl = fl; v.oc = oc; v.cond = cond;
        v.op1 = op1; v.op2 = op2; v.imm = imm; v.pc = pc; v.off = off; v.fin = fin;
        v.e_res = e_res; v.e_flags = e_flags; v.e_we = e_we; v.e_tk = e_tk;
        v.e_tgt = e_tgt; v.chk_tgt = chk_tgt; v.lat = lat;
        return v;
    endfunction

    function automatic int lat_of(int amt);
`ifdef EX_BARREL_SHIFT_EN
        return 1;
`else
        return amt + 1;
`endif
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        bus.special_enc = v.spec;
        bus.first_ld    = v.fl;
        bus.alu_oc      = v.oc;
        bus.b_cond      = v.cond;
        bus.op1         = v.op1;
        bus.op2         = v.op2;
        bus.imm         = v.imm;
        bus.pc          = v.pc;
        bus.offset      = v.off;
        bus.flags_in    = v.fin;
    endtask

    task automatic run_vec(vec_t v);
        int lat;
        bit saw_ready;
        @(negedge clk);
        drive(v);
        bus.in_valid = 1'b1;
        chk({v.name, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        saw_ready = 1'b0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            if (bus.in_ready) saw_ready = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk({v.name, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({v.name, ".latency"}, 32'(lat), 32'(v.lat));
        chk({v.name, ".result"}, 32'(bus.result), 32'(v.e_res));
        chk({v.name, ".flags_we"}, 32'(bus.flags_we), 32'(v.e_we));
        if (v.e_we) chk({v.name, ".flags"}, 32'(bus.flags_out), 32'(v.e_flags));
        chk({v.name, ".br_taken"}, 32'(bus.br_taken), 32'(v.e_tk));
        if (v.chk_tgt) chk({v.name, ".br_target"}, 32'(bus.br_target), 32'(v.e_tgt));
        if (v.lat > 1) chk({v.name, ".in_ready_busy"}, 32'(saw_ready), 32'd0);
        @(posedge clk); #1;
        chk({v.name, ".drain_valid"}, 32'(bus.out_valid), 32'd0);
        chk({v.name, ".drain_qual"}, {30'd0, bus.flags_we, bus.br_taken}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t a, b;
        //      name         sp fl  oc cnd op1      op2      imm      pc       off      fin      res      flg      we tk tgt      ct lat
        vt.push_back(mk("add_ovf",   1, 0, 1, 0, 16'h7FFF, 16'h0000, 16'h0001, 16'h0, 16'h0, 4'h0, 16'h8000, 4'b1001, 1, 0, 16'h0, 0, 1));
        vt.push_back(mk("sub_eq",    1, 1, 2, 0, 16'h0005, 16'h0005, 16'h0000, 16'h0, 16'h0, 4'h0, 16'h0000, 4'b0110, 1, 0, 16'h0, 0, 1));
        vt.push_back(mk("sub_neg",   1, 1, 2, 0, 16'h0003, 16'h0005, 16'h0000, 16'h0, 16'h0, 4'h0, 16'hFFFE, 4'b1000, 1, 0, 16'h0, 0, 1));
        vt.push_back(mk("add_cy",    1, 1, 1, 0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0, 16'h0, 4'h0, 16'h0000, 4'b0110, 1, 0, 16'h0, 0, 1));
        vt.push_back(mk("and",       1, 1, 3, 0, 16'hF0F0, 16'h0FF0, 16'h0000, 16'h0, 16'h0, 4'h3, 16'h00F0, 4'b0011, 1, 0, 16'h0, 0, 1));
        vt.push_back(mk("or_imm",    1, 0, 4, 0, 16'h8000, 16'hFFFF, 16'h0001, 16'h0, 16'h0, 4'h0, 16'h8001, 4'b1000, 1, 0, 16'h0, 0, 1));
        vt.push_back(mk("xor",       1, 1, 5, 0, 16'hAAAA, 16'hAAAA, 16'h0000, 16'h0, 16'h0, 4'h2, 16'h0000, 4'b0110, 1, 0, 16'h0, 0, 1));
        vt.push_back(mk("not",       1, 0, 6, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0, 16'h0, 4'h1, 16'hFFFF, 4'b1001, 1, 0, 16'h0, 0, 1));
        vt.push_back(mk("alu_000",   1, 1, 0, 0, 16'h1234, 16'h0001, 16'h0000, 16'h0, 16'h0, 4'h0, 16'h0000, 4'b0000, 0, 0, 16'h0, 0, 1));
        vt.push_back(mk("alu_111",   1, 1, 7, 0, 16'h1234, 16'h0001, 16'h0000, 16'h0, 16'h0, 4'h0, 16'h0000, 4'b0000, 0, 0, 16'h0, 0, 1));
        vt.push_back(mk("mov",       0, 0, 0, 0, 16'hFFFF, 16'h0000, 16'h1234, 16'h0, 16'h0, 4'h0, 16'h1234, 4'b0000, 0, 0, 16'h0, 0, 1));
        vt.push_back(mk("movt",      0, 0, 1, 0, 16'hABCD, 16'h0000, 16'h0012, 16'h0, 16'h0, 4'h0, 16'h12CD, 4'b0000, 0, 0, 16'h0, 0, 1));
        vt.push_back(mk("clr",       0, 0, 2, 0, 16'hFFFF, 16'h0000, 16'h0003, 16'h0, 16'h0, 4'h0, 16'hFFF7, 4'b0000, 0, 0, 16'h0, 0, 1));
        vt.push_back(mk("set",       0, 0, 3, 0, 16'h0000, 16'h0000, 16'h000F, 16'h0, 16'h0, 4'h0, 16'h8000, 4'b0000, 0, 0, 16'h0, 0, 1));
        vt.push_back(mk("lsl0",      0, 0, 4, 0, 16'h1234, 16'h0000, 16'h0000, 16'h0, 16'h0, 4'h0, 16'h1234, 4'b0000, 0, 0, 16'h0, 0, 1));
        vt.push_back(mk("lsl_b5",    0, 0, 4, 0, 16'h1234, 16'h0000, 16'h0020, 16'h0, 16'h0, 4'h0, 16'h1234, 4'b0000, 0, 0, 16'h0, 0, 1));
        vt.push_back(mk("lsl16",     0, 0, 4, 0, 16'h0001, 16'h0000, 16'h0010, 16'h0, 16'h0, 4'h0, 16'h0000, 4'b0000, 0, 0, 16'h0, 0, 1));
        vt.push_back(mk("lsr31",     0, 0, 5, 0, 16'h8000, 16'h0000, 16'h001F, 16'h0, 16'h0, 4'h0, 16'h0000, 4'b0000, 0, 0, 16'h0, 0, 1));
        vt.push_back(mk("lsl4",      0, 0, 4, 0, 16'h0001, 16'h0000, 16'h0004, 16'h0, 16'h0, 4'h0, 16'h0010, 4'b0000, 0, 0, 16'h0, 0, lat_of(4)));
        vt.push_back(mk("lsr15",     0, 0, 5, 0, 16'h8000, 16'h0000, 16'h000F, 16'h0, 16'h0, 4'h0, 16'h0001, 4'b0000, 0, 0, 16'h0, 0, lat_of(15)));
        vt.push_back(mk("lsl1",      0, 0, 4, 0, 16'hC001, 16'h0000, 16'h0001, 16'h0, 16'h0, 4'h0, 16'h8002, 4'b0000, 0, 0, 16'h0, 0, lat_of(1)));
        vt.push_back(mk("lsr3",      0, 0, 5, 0, 16'hF0F0, 16'h0000, 16'h0003, 16'h0, 16'h0, 4'h0, 16'h1E1E, 4'b0000, 0, 0, 16'h0, 0, lat_of(3)));
        vt.push_back(mk("mv_110",    0, 0, 6, 0, 16'h1234, 16'h0000, 16'h1234, 16'h0, 16'h0, 4'h0, 16'h0000, 4'b0000, 0, 0, 16'h0, 0, 1));
        vt.push_back(mk("b",         0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 16'hFFFC, 4'h0, 16'h0, 4'h0, 0, 1, 16'h000C, 1, 1));
        vt.push_back(mk("b_wrap",    0, 3, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'hFFF0, 16'h0020, 4'h0, 16'h0, 4'h0, 0, 1, 16'h0010, 1, 1));
        vt.push_back(mk("bcc_eq_t",  0, 1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 16'hFFFC, 4'b0100, 16'h0, 4'h0, 0, 1, 16'h000C, 1, 1));
        vt.push_back(mk("bcc_eq_nt", 0, 1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 16'hFFFC, 4'b0000, 16'h0, 4'h0, 0, 0, 16'h000C, 1, 1));
        vt.push_back(mk("bcc_ne",    0, 1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0020, 4'b0000, 16'h0, 4'h0, 0, 1, 16'h0120, 1, 1));
        vt.push_back(mk("bcc_cs",    0, 1, 1, 2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 4'b0010, 16'h0, 4'h0, 0, 1, 16'h0004, 1, 1));
        vt.push_back(mk("bcc_mi",    0, 1, 1, 4, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 4'b0000, 16'h0, 4'h0, 0, 0, 16'h0004, 1, 1));
        vt.push_back(mk("bcc_vs",    0, 1, 1, 6, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 4'b0001, 16'h0, 4'h0, 0, 1, 16'h0004, 1, 1));
        vt.push_back(mk("bcc_hi",    0, 1, 1, 8, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 4'b0010, 16'h0, 4'h0, 0, 1, 16'h0004, 1, 1));
        vt.push_back(mk("bcc_ls",    0, 1, 1, 9, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 4'b0010, 16'h0, 4'h0, 0, 0, 16'h0004, 1, 1));
        vt.push_back(mk("bcc_lt",    0, 1, 1, 11, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 4'b0001, 16'h0, 4'h0, 0, 1, 16'h0004, 1, 1));
        vt.push_back(mk("bcc_gt_t",  0, 1, 1, 12, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 4'b0000, 16'h0, 4'h0, 0, 1, 16'h0004, 1, 1));
        vt.push_back(mk("bcc_gt_nt", 0, 1, 1, 12, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 4'b1000, 16'h0, 4'h0, 0, 0, 16'h0004, 1, 1));
        vt.push_back(mk("bcc_le",    0, 1, 1, 13, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 4'b1000, 16'h0, 4'h0, 0, 1, 16'h0004, 1, 1));
        vt.push_back(mk("bcc_al",    0, 1, 1, 14, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 4'b0000, 16'h0, 4'h0, 0, 1, 16'h0004, 1, 1));
        vt.push_back(mk("bcc_nv",    0, 1, 1, 15, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 4'b1111, 16'h0, 4'h0, 0, 0, 16'h0004, 1, 1));
        vt.push_back(mk("br",        0, 2, 2, 0, 16'hABCD, 16'h0000, 16'h0000, 16'h0010, 16'h0004, 4'h0, 16'h0, 4'h0, 0, 1, 16'hABCD, 1, 1));
        vt.push_back(mk("br_nop",    0, 3, 3, 0, 16'hABCD, 16'h0000, 16'h0000, 16'h0010, 16'h0004, 4'h0, 16'h0, 4'h0, 0, 0, 16'h0, 0, 1));

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(vt[0]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset.result", 32'(bus.result), 32'd0);
        chk("reset.flags", {28'd0, bus.flags_out}, 32'd0);
        chk("reset.qual", {30'd0, bus.flags_we, bus.br_taken}, 32'd0);
        chk("reset.br_target", 32'(bus.br_target), 32'd0);

        foreach (vt[i]) run_vec(vt[i]);

        // Back-to-back accepts with downstream always ready.
        @(negedge clk);
        drive(mk("tp1", 1, 1, 1, 0, 16'h0001, 16'h0002, 16'h0, 16'h0, 16'h0, 4'h0, 16'h0, 4'h0, 0, 0, 16'h0, 0, 1));
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("tp.first", 32'(bus.result), 32'h0003);
        drive(mk("tp2", 1, 0, 1, 0, 16'h0010, 16'h0000, 16'h0020, 16'h0, 16'h0, 4'h0, 16'h0, 4'h0, 0, 0, 16'h0, 0, 1));
        chk("tp.ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("tp.second", 32'(bus.result), 32'h0030);
        chk("tp.valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;

        // Backpressure: second op must wait, first result must hold.
        a = mk("bp_a", 1, 0, 1, 0, 16'h7FFF, 16'h0000, 16'h0001, 16'h0, 16'h0, 4'h0, 16'h0, 4'h0, 0, 0, 16'h0, 0, 1);
        b = mk("bp_b", 1, 1, 2, 0, 16'h0009, 16'h0002, 16'h0000, 16'h0, 16'h0, 4'h0, 16'h0, 4'h0, 0, 0, 16'h0, 0, 1);
        @(negedge clk);
        drive(a);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        drive(b);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp.hold_result", 32'(bus.result), 32'h8000);
            chk("bp.hold_flags", {27'd0, bus.flags_we, bus.flags_out}, {27'd0, 1'b1, 4'b1001});
            chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk("bp.release_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp.second_result", 32'(bus.result), 32'h0007);
        chk("bp.second_flags", {28'd0, bus.flags_out}, 32'b0010);
        chk("bp.second_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;
        chk("bp.drained", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset in the middle of an iterative shift.
        @(negedge clk);
        drive(mk("rs", 0, 0, 4, 0, 16'h0001, 16'h0000, 16'h0008, 16'h0, 16'h0, 4'h0, 16'h0, 4'h0, 0, 0, 16'h0, 0, 1));
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
`ifndef EX_BARREL_SHIFT_EN
        chk("rs.busy", {30'd0, bus.in_ready, bus.out_valid}, 32'd0);
`endif
        rst = 1'b1;
        #1;
        chk("rs.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rs.result", 32'(bus.result), 32'd0);
        chk("rs.others", {bus.br_target, 10'd0, bus.flags_out, bus.flags_we, bus.br_taken},
            32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rs.in_ready", 32'(bus.in_ready), 32'd1);
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("rs.discarded", 32'(bus.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
